fifo_pkt_sched: RTL and testbench
=================================

Name: fifo_pkt_sched

Overview:
- Packet-level scheduler that drives the writeReq/readReq controls of fifo_2048.
- Admits whole upstream packets into the FIFO only while the configured packet limit and the FIFO capacity allow.
- Releases packets to the read side in store-and-forward or cut-through mode.
- Sits beside fifo_2048. It observes both AXIS handshakes and maintains word and packet occupancy counters.

Parameters:
- DataWidth, 32, data width of the scheduled FIFO (used for documentation and bench only).
- Depth, 2048, FIFO depth in words; power of two.
- PktCntWidth, 8, width of the packet counter and of cfg_max_pkts.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_enable  in  1  admit new packets when 1
- cfg_store_fwd  in  1  1 = release only complete packets; 0 = cut-through
- cfg_max_pkts  in  PktCntWidth  maximum complete packets held; 0 means no limit
- writeDataValid  in  1  upstream beat valid (FIFO write side)
- writeDataReady  in  1  FIFO write-side ready
- writeDataLast  in  1  upstream beat is end of packet
- readDataValid  in  1  FIFO read-side valid
- readDataReady  in  1  downstream ready
- readDataLast  in  1  read beat is end of packet
- full  in  1  FIFO full
- empty  in  1  FIFO empty
- writeReq  out  1  write enable to FIFO (registered)
- readReq  out  1  read enable to FIFO (registered)
- word_count  out  $clog2(Depth)+1  words currently stored
- pkt_count  out  PktCntWidth  complete packets currently stored
- wr_busy  out  1  write FSM in W_PKT
- rd_busy  out  1  read FSM in R_PKT
- err  out  1  sticky protocol error

Behaviour:
Reset:
- All outputs are 0.
- Both FSMs return to IDLE.
- Reset mid-packet abandons the packet, with no flush of FIFO contents.

Beat definitions:
- wbeat = writeReq & writeDataValid & writeDataReady.
- rbeat = readReq & readDataValid & readDataReady.

word_count:
- Increments on wbeat and decrements on rbeat.
- Unchanged when both occur in the same cycle.
- Saturates at 0 and at Depth.

Write FSM:
- W_IDLE:
  - writeReq <= cfg_enable & !full & (cfg_max_pkts==0 | pkt_count<cfg_max_pkts).
  - The condition is registered, so writeReq follows it with one cycle of latency.
  - First wbeat moves the FSM to W_PKT. If that beat has writeDataLast, the FSM stays in W_IDLE and the packet is counted.
- W_PKT:
  - writeReq is held at 1 regardless of cfg_enable or the packet limit; packets are never truncated.
  - Backpressure comes only via writeDataReady.
  - wbeat with writeDataLast: pkt_count +1, return to W_IDLE, writeReq re-evaluated the next cycle.

Read FSM:
- R_IDLE:
  - readReq <= cfg_store_fwd ? (pkt_count!=0) : (word_count!=0).
  - First rbeat moves the FSM to R_PKT, unless it has readDataLast.
- R_PKT:
  - readReq is held at 1 until rbeat with readDataLast.
  - On that beat: pkt_count −1 if a complete packet was counted; return to R_IDLE.
- Cut-through: the packet being read may still be in W_PKT. pkt_count decrements only for packets already counted. A per-packet "counted" flag tracks the oldest packet.

Packet count and limits:
- Simultaneous increment and decrement of pkt_count: no change.
- pkt_count saturates at 2^PktCntWidth−1. A further increment sets err.

err is sticky until reset. It is set on any of:
- wbeat while full
- rbeat while word_count==0
- readDataLast on rbeat while word_count==0
- pkt_count overflow

Boundaries:
- full rising in W_PKT: writeReq stays 1 and the FIFO's writeDataReady stalls.
- word_count==Depth and writeReq==1: flag err only if a beat is accepted.
- cfg changes take effect at the next IDLE evaluation only.

Test Plan:
1. Store-and-forward, 16-beat packets (counter 0..15, last on beat 15), cfg_max_pkts=4, readDataReady=1:
   - readReq stays 0 until the cycle after beat 15 is written; then pkt_count=1 and readReq=1.
   - 16 reads, pkt_count returns to 0.
2. Packet limit: cfg_max_pkts=2, reads blocked:
   - After 32 beats, writeReq=0 with pkt_count=2 and word_count=32.
   - Release one packet → writeReq=1 one cycle after pkt_count=1.
3. cfg_enable cleared at beat 5 of a packet:
   - writeReq stays 1 through beat 15; pkt_count=1; writeReq=0 afterwards.
4. Cut-through: cfg_store_fwd=0:
   - readReq=1 one cycle after the first write beat.
   - Simultaneous wbeat/rbeat keeps word_count constant.
   - Final pkt_count=0; err=0.
5. Fill to full: Depth=2048, 128 packets of 16 beats, cfg_max_pkts=0, no reads:
   - word_count=2048, pkt_count=128, full=1, writeReq=0, err=0.
6. reset asserted at beat 7 of a packet:
   - Next cycle: writeReq=0, readReq=0, word_count=0, pkt_count=0, wr_busy=0, err=0.

Source files
------------

// File: rtl/fifo_pkt_sched.sv
// -----------------------------------------------------------------------------
// fifo_pkt_sched
//
// Packet-level scheduler that sits beside a word FIFO (fifo_2048) and drives
// its writeReq/readReq enables. It watches both AXIS-style handshakes and
// keeps word and complete-packet occupancy counters.
//
// Write side: whole packets are admitted only while cfg_enable is set, the
// FIFO is not full and the packet limit allows it. Once a packet has started
// it is never truncated; backpressure then comes only from writeDataReady.
//
// Read side: store-and-forward (release only complete packets) or
// cut-through (release as soon as any word is stored).
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cfg_enable                  admit new packets
//   cfg_store_fwd               1 = store-and-forward, 0 = cut-through
//   cfg_max_pkts                complete-packet limit, 0 = unlimited
//   writeDataValid/Ready/Last   write-side handshake observed
//   readDataValid/Ready/Last    read-side handshake observed
//   full, empty                 FIFO status flags
//   writeReq, readReq           registered FIFO enables
//   word_count, pkt_count       occupancy counters
//   wr_busy, rd_busy            FSMs are inside a packet
//   err                         sticky protocol error
// -----------------------------------------------------------------------------
module fifo_pkt_sched #(
  parameter int DataWidth   = 32,
  parameter int Depth       = 2048,
  parameter int PktCntWidth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_enable,
  input  logic                     cfg_store_fwd,
  input  logic [PktCntWidth-1:0]   cfg_max_pkts,
  input  logic                     writeDataValid,
  input  logic                     writeDataReady,
  input  logic                     writeDataLast,
  input  logic                     readDataValid,
  input  logic                     readDataReady,
  input  logic                     readDataLast,
  input  logic                     full,
  input  logic                     empty,
  output logic                     writeReq,
  output logic                     readReq,
  output logic [$clog2(Depth):0]   word_count,
  output logic [PktCntWidth-1:0]   pkt_count,
  output logic                     wr_busy,
  output logic                     rd_busy,
  output logic                     err
);

  localparam int CntW = $clog2(Depth) + 1;

  // Elaboration-time guard on the parameter set.
  if (DataWidth < 1 || (Depth & (Depth - 1)) != 0) begin : gParamCheck
    $error("fifo_pkt_sched: DataWidth must be >= 1 and Depth a power of two");
  end

  typedef enum logic {W_IDLE, W_PKT} wrState_t;
  typedef enum logic {R_IDLE, R_PKT} rdState_t;

  wrState_t          wrStateReg, wrStateNext;
  rdState_t          rdStateReg, rdStateNext;
  logic              writeReqNext, readReqNext;
  logic [CntW-1:0]   wordCountNext;
  logic [PktCntWidth-1:0] pktCountNext;
  logic              errNext;

  logic wbeat, rbeat;
  logic limitOk, admit, releaseOk;
  logic pktInc, pktDec, oldestCounted, pktSat;

  assign wbeat = writeReq & writeDataValid & writeDataReady;
  assign rbeat = readReq & readDataValid & readDataReady;

  assign limitOk   = (cfg_max_pkts == '0) | (pkt_count < cfg_max_pkts);
  assign admit     = cfg_enable & ~full & limitOk;
  assign releaseOk = cfg_store_fwd ? (pkt_count != '0) : (word_count != '0);

  // The oldest stored packet has been counted if any complete packet is held,
  // or if its final beat is being written in this very cycle (cut-through).
  assign pktInc        = wbeat & writeDataLast;
  assign oldestCounted = (pkt_count != '0) | pktInc;
  assign pktDec        = rbeat & readDataLast & oldestCounted;
  assign pktSat        = &pkt_count;

  assign wr_busy = (wrStateReg == W_PKT);
  assign rd_busy = (rdStateReg == R_PKT);

  // Write FSM. A packet's final beat always drops writeReq for one cycle so
  // admission is re-evaluated against the updated packet count.
  always_comb begin
    wrStateNext  = wrStateReg;
    writeReqNext = writeReq;
    unique case (wrStateReg)
      W_IDLE: begin
        if (wbeat) begin
          if (writeDataLast) begin
            writeReqNext = 1'b0;
          end else begin
            wrStateNext  = W_PKT;
            writeReqNext = 1'b1;
          end
        end else begin
          writeReqNext = admit;
        end
      end
      W_PKT: begin
        writeReqNext = 1'b1;
        if (wbeat && writeDataLast) begin
          wrStateNext  = W_IDLE;
          writeReqNext = 1'b0;
        end
      end
      default: begin
        wrStateNext  = W_IDLE;
        writeReqNext = 1'b0;
      end
    endcase
  end

  // Read FSM, same structure as the write side.
  always_comb begin
    rdStateNext = rdStateReg;
    readReqNext = readReq;
    unique case (rdStateReg)
      R_IDLE: begin
        if (rbeat) begin
          if (readDataLast) begin
            readReqNext = 1'b0;
          end else begin
            rdStateNext = R_PKT;
            readReqNext = 1'b1;
          end
        end else begin
          readReqNext = releaseOk;
        end
      end
      R_PKT: begin
        readReqNext = 1'b1;
        if (rbeat && readDataLast) begin
          rdStateNext = R_IDLE;
          readReqNext = 1'b0;
        end
      end
      default: begin
        rdStateNext = R_IDLE;
        readReqNext = 1'b0;
      end
    endcase
  end

  // Occupancy counters and error detection.
  always_comb begin
    wordCountNext = word_count;
    if (wbeat && !rbeat && word_count != CntW'(Depth)) begin
      wordCountNext = word_count + 1'b1;
    end else if (rbeat && !wbeat && word_count != '0) begin
      wordCountNext = word_count - 1'b1;
    end

    pktCountNext = pkt_count;
    if (pktInc && !pktDec && !pktSat) begin
      pktCountNext = pkt_count + 1'b1;
    end else if (pktDec && !pktInc) begin
      pktCountNext = pkt_count - 1'b1;
    end

    // A read beat with nothing stored (by our count or by the FIFO's own
    // flag) covers the read-last-while-empty case as well.
    errNext = err
            | (wbeat & full)
            | (rbeat & ((word_count == '0) | empty))
            | (pktInc & ~pktDec & pktSat);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrStateReg <= W_IDLE;
      rdStateReg <= R_IDLE;
      writeReq   <= 1'b0;
      readReq    <= 1'b0;
      word_count <= '0;
      pkt_count  <= '0;
      err        <= 1'b0;
    end else begin
      wrStateReg <= wrStateNext;
      rdStateReg <= rdStateNext;
      writeReq   <= writeReqNext;
      readReq    <= readReqNext;
      word_count <= wordCountNext;
      pkt_count  <= pktCountNext;
      err        <= errNext;
    end
  end

endmodule

// File: tb/tb_fifo_pkt_sched.sv
// -----------------------------------------------------------------------------
// tb_fifo_pkt_sched
//
// Bench for fifo_pkt_sched. The bench plays the roles of the upstream packet
// source, the FIFO itself (a queue of end-of-packet flags) and the downstream
// sink. Expected occupancy comes from that queue; expected packet state comes
// from counting packet boundaries seen on the handshakes.
// -----------------------------------------------------------------------------
module tb_fifo_pkt_sched;

  localparam int DEPTH = 2048;
  localparam int PKTW  = 8;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic            clk;
  logic            reset;
  logic            cfg_enable;
  logic            cfg_store_fwd;
  logic [PKTW-1:0] cfg_max_pkts;
  logic            writeDataValid, writeDataReady, writeDataLast;
  logic            readDataValid, readDataReady, readDataLast;
  logic            full, empty;
  logic            writeReq, readReq;
  logic [CNTW-1:0] word_count;
  logic [PKTW-1:0] pkt_count;
  logic            wr_busy, rd_busy, err;

  fifo_pkt_sched #(
    .DataWidth   (32),
    .Depth       (DEPTH),
    .PktCntWidth (PKTW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_enable     (cfg_enable),
    .cfg_store_fwd  (cfg_store_fwd),
    .cfg_max_pkts   (cfg_max_pkts),
    .writeDataValid (writeDataValid),
    .writeDataReady (writeDataReady),
    .writeDataLast  (writeDataLast),
    .readDataValid  (readDataValid),
    .readDataReady  (readDataReady),
    .readDataLast   (readDataLast),
    .full           (full),
    .empty          (empty),
    .writeReq       (writeReq),
    .readReq        (readReq),
    .word_count     (word_count),
    .pkt_count      (pkt_count),
    .wr_busy        (wr_busy),
    .rd_busy        (rd_busy),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit q[$];            // FIFO contents: one end-of-packet flag per word
  int mdlPkts;         // complete packets whose last word is stored
  bit wrOpen, rdOpen;  // a packet is partially written / partially read
  int srcLeft;         // packets the source still has to send
  int srcLen;          // length of the packet being sent
  int beatIdx;         // beats already sent of that packet
  bit randLen;
  int validPct, wrReadyPct, sinkPct;
  int wordsWritten, wordsRead, pktsRead;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic newLen();
    srcLen = randLen ? int'($urandom_range(16, 1)) : 16;
  endtask

  task automatic driveInputs();
    writeDataValid = (srcLeft > 0) && ($urandom_range(99) < validPct);
    writeDataLast  = (beatIdx == srcLen - 1);
    writeDataReady = (q.size() < DEPTH) && ($urandom_range(99) < wrReadyPct);
    full           = (q.size() == DEPTH);
    empty          = (q.size() == 0);
    readDataValid  = !empty;
    readDataLast   = empty ? 1'b0 : q[0];
    readDataReady  = ($urandom_range(99) < sinkPct);
  endtask

  task automatic checkState();
    chk("word_count", word_count, q.size());
    chk("pkt_count", pkt_count, mdlPkts);
    chk("wr_busy", wr_busy, wrOpen);
    chk("rd_busy", rd_busy, rdOpen);
    chk("err_clear", err, 0);
  endtask

  // One clock: decide which handshakes complete, advance the model, check.
  task automatic step();
    bit wb, rb, l;
    int sizeBefore;
    wb = writeReq && writeDataValid && writeDataReady;
    rb = readReq && readDataValid && readDataReady;
    sizeBefore = q.size();
    @(posedge clk);
    if (rb) begin
      l = q.pop_front();
      wordsRead++;
      rdOpen = !l;
      if (l) begin
        mdlPkts--;
        pktsRead++;
      end
    end
    if (wb) begin
      q.push_back(writeDataLast);
      wordsWritten++;
      if (writeDataLast) begin
        mdlPkts++;
        srcLeft--;
        beatIdx = 0;
        wrOpen  = 1'b0;
        newLen();
      end else begin
        beatIdx++;
        wrOpen = 1'b1;
      end
    end
    #1;
    checkState();
    if (wb && rb) chk("simul_wr_rd_word_count", word_count, sizeBefore);
    driveInputs();
  endtask

  task automatic applyReset();
    reset          = 1'b1;
    writeDataValid = 1'b0;
    writeDataReady = 1'b0;
    writeDataLast  = 1'b0;
    readDataValid  = 1'b0;
    readDataReady  = 1'b0;
    readDataLast   = 1'b0;
    full           = 1'b0;
    empty          = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    mdlPkts = 0; wrOpen = 0; rdOpen = 0;
    srcLeft = 0; beatIdx = 0; srcLen = 16;
    wordsWritten = 0; wordsRead = 0; pktsRead = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cfg_enable = 1'b0; cfg_store_fwd = 1'b1; cfg_max_pkts = '0;
    randLen = 0; validPct = 100; wrReadyPct = 100; sinkPct = 100;
    applyReset();
    chk("reset_writeReq", writeReq, 0);
    chk("reset_readReq", readReq, 0);
    checkState();

    // 1: store-and-forward, one 16-beat packet
    applyReset();
    cfg_enable = 1; cfg_store_fwd = 1; cfg_max_pkts = 4;
    randLen = 0; validPct = 100; wrReadyPct = 100; sinkPct = 100;
    srcLeft = 1; newLen(); driveInputs();
    n = 0;
    while (srcLeft > 0 && n < 100) begin
      step(); n++;
      chk("t1_readReq_low_while_writing", readReq, 0);
    end
    chk("t1_packet_written", srcLeft, 0);
    chk("t1_pkt_count_after_last", pkt_count, 1);
    step();
    chk("t1_readReq_cycle_after_last", readReq, 1);
    n = 0;
    while ((q.size() > 0 || rdOpen) && n < 100) begin step(); n++; end
    chk("t1_words_read", wordsRead, 16);
    chk("t1_pkt_count_final", pkt_count, 0);
    $display("[TB] t1 store-and-forward: words read %0d", wordsRead);

    // 2: packet limit of 2 with reads blocked, then release one packet
    applyReset();
    cfg_enable = 1; cfg_store_fwd = 1; cfg_max_pkts = 2; sinkPct = 0;
    srcLeft = 3; newLen(); driveInputs();
    n = 0;
    while (wordsWritten < 32 && n < 200) begin step(); n++; end
    repeat (3) step();
    chk("t2_writeReq_blocked", writeReq, 0);
    chk("t2_pkt_count_at_limit", pkt_count, 2);
    chk("t2_word_count_at_limit", word_count, 32);
    chk("t2_no_extra_words", wordsWritten, 32);
    sinkPct = 100; driveInputs();
    n = 0;
    while (pktsRead < 1 && n < 100) begin step(); n++; end
    chk("t2_pkt_count_released", pkt_count, 1);
    chk("t2_writeReq_same_cycle", writeReq, 0);
    step();
    chk("t2_writeReq_reopens", writeReq, 1);
    n = 0;
    while ((srcLeft > 0 || q.size() > 0 || rdOpen) && n < 500) begin step(); n++; end
    chk("t2_all_packets_read", pktsRead, 3);
    $display("[TB] t2 packet limit: packets read %0d", pktsRead);

    // 3: cfg_enable dropped mid-packet
    applyReset();
    cfg_enable = 1; cfg_store_fwd = 1; cfg_max_pkts = 0; sinkPct = 0;
    srcLeft = 2; newLen(); driveInputs();
    n = 0;
    while (wordsWritten < 5 && n < 100) begin step(); n++; end
    cfg_enable = 0;
    n = 0;
    while (srcLeft == 2 && n < 100) begin
      step(); n++;
      if (srcLeft == 2) chk("t3_writeReq_held", writeReq, 1);
    end
    chk("t3_writeReq_drops", writeReq, 0);
    repeat (3) step();
    chk("t3_writeReq_stays_low", writeReq, 0);
    chk("t3_pkt_count", pkt_count, 1);
    chk("t3_word_count", word_count, 16);
    $display("[TB] t3 enable drop: words written %0d", wordsWritten);

    // 4: cut-through with random lengths and handshakes
    applyReset();
    cfg_enable = 1; cfg_store_fwd = 0; cfg_max_pkts = 0;
    randLen = 1; validPct = 80; wrReadyPct = 80; sinkPct = 70;
    srcLeft = 20; newLen(); driveInputs();
    n = 0;
    while (wordsWritten == 0 && n < 100) begin step(); n++; end
    chk("t4_readReq_at_first_beat", readReq, 0);
    step();
    chk("t4_readReq_after_first_beat", readReq, 1);
    n = 0;
    while ((srcLeft > 0 || q.size() > 0 || rdOpen) && n < 5000) begin step(); n++; end
    chk("t4_drained", q.size(), 0);
    chk("t4_pkts_read", pktsRead, 20);
    chk("t4_pkt_count_final", pkt_count, 0);
    chk("t4_err_final", err, 0);
    $display("[TB] t4 cut-through: packets read %0d words %0d", pktsRead, wordsRead);

    // 5: fill the FIFO completely
    applyReset();
    cfg_enable = 1; cfg_store_fwd = 1; cfg_max_pkts = 0;
    randLen = 0; validPct = 100; wrReadyPct = 100; sinkPct = 0;
    srcLeft = 128; newLen(); driveInputs();
    n = 0;
    while (srcLeft > 0 && n < 3000) begin step(); n++; end
    repeat (3) step();
    chk("t5_word_count_full", word_count, DEPTH);
    chk("t5_pkt_count_full", pkt_count, 128);
    chk("t5_writeReq_full", writeReq, 0);
    chk("t5_err_full", err, 0);
    $display("[TB] t5 fill: word_count %0d pkt_count %0d", word_count, pkt_count);

    // 6: reset in the middle of a packet
    applyReset();
    cfg_enable = 1; cfg_store_fwd = 0; cfg_max_pkts = 0;
    validPct = 100; wrReadyPct = 100; sinkPct = 100;
    srcLeft = 1; newLen(); driveInputs();
    n = 0;
    while (wordsWritten < 7 && n < 100) begin step(); n++; end
    chk("t6_busy_before_reset", wr_busy, 1);
    applyReset();
    chk("t6_writeReq", writeReq, 0);
    chk("t6_readReq", readReq, 0);
    chk("t6_word_count", word_count, 0);
    chk("t6_pkt_count", pkt_count, 0);
    chk("t6_wr_busy", wr_busy, 0);
    chk("t6_rd_busy", rd_busy, 0);
    chk("t6_err", err, 0);
    $display("[TB] t6 mid-packet reset done");

    // 7: beat accepted while the FIFO reports full sets sticky err
    applyReset();
    cfg_enable = 1; cfg_store_fwd = 1; sinkPct = 0;
    srcLeft = 1; newLen(); driveInputs();
    n = 0;
    while (wordsWritten < 3 && n < 100) begin step(); n++; end
    full = 1; writeDataReady = 1; writeDataValid = 1; writeDataLast = 0;
    @(posedge clk); #1;
    chk("t7_err_on_full_write", err, 1);
    full = 0; writeDataValid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("t7_err_sticky", err, 1);
    applyReset();
    chk("t7_err_cleared_by_reset", err, 0);
    $display("[TB] t7 error flag checked");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
